// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_pkg
// Description : Shared constants, address decode type and helper for the
//               performance-counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

    localparam int NUM_CTR_DEFAULT = 8;
    localparam int WIDTH_DEFAULT   = 32;
    localparam int ADDR_W          = 5;
    localparam logic [ADDR_W-1:0] OVF_ADDR = 5'h1F;

    typedef enum logic [1:0] {
        RD_CTR = 2'd0,
        RD_OVF = 2'd1,
        RD_ERR = 2'd2
    } rd_sel_e;

    function automatic rd_sel_e decode_addr(input logic [ADDR_W-1:0] addr,
                                            input int num_ctr);
        if (addr == OVF_ADDR)
            return RD_OVF;
        else if (int'(addr) < num_ctr)
            return RD_CTR;
        else
            return RD_ERR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/perf_ctr_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : perf_ctr_bank_if
// Description : Read request/response bus of the performance-counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface perf_ctr_bank_if
    import perf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_valid_o;
    logic [WIDTH-1:0]  rd_data_o;
    logic              rd_err_o;

    modport master (
        output rd_req_i, rd_addr_i,
        input  rd_valid_o, rd_data_o, rd_err_o
    );

    modport slave (
        input  rd_req_i, rd_addr_i,
        output rd_valid_o, rd_data_o, rd_err_o
    );

endinterface
`default_nettype wire

// File: rtl/perf_ctr_slice.sv
`default_nettype none
// ============================================================================
// Module      : perf_ctr_slice
// Description : One event counter with sticky wrap flag. With PERF_SNAPSHOT_EN
//               a shadow copy is kept and presented as the read value.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_ctr_slice #(
    parameter int WIDTH = 32
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              clr,
    input  wire              inc,
`ifdef PERF_SNAPSHOT_EN
    input  wire              snap,
`endif
    output logic [WIDTH-1:0] rd_val,
    output logic             ovf
);

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
`ifdef PERF_SNAPSHOT_EN
    logic [WIDTH-1:0] r_shadow;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count  <= '0;
            r_ovf    <= 1'b0;
`ifdef PERF_SNAPSHOT_EN
            r_shadow <= '0;
`endif
        end else begin
            if (inc) begin
                r_count <= r_count + WIDTH'(1);
                if (&r_count)
                    r_ovf <= 1'b1;
            end
`ifdef PERF_SNAPSHOT_EN
            // Shadow captures the value before any coincident increment
            if (snap)
                r_shadow <= r_count;
`endif
        end
    end

`ifdef PERF_SNAPSHOT_EN
    assign rd_val = r_shadow;
`else
    assign rd_val = r_count;
`endif
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/perf_ctr_bank.sv
`default_nettype none
// ============================================================================
// Module      : perf_ctr_bank
// Description : Bank of NUM_CTR event counters with sticky overflow flags,
//               one-cycle read port and level overflow interrupt.
//               Optional snapshot shadows enabled by macro PERF_SNAPSHOT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_ctr_bank
    import perf_pkg::*;
#(
    parameter int NUM_CTR = NUM_CTR_DEFAULT,
    parameter int WIDTH   = WIDTH_DEFAULT
) (
    input  wire                clk,
    input  wire                rst,
    input  wire  [NUM_CTR-1:0] event_i,
    input  wire                enable_i,
    input  wire                clr_i,
    input  wire                snap_i,
    input  wire  [NUM_CTR-1:0] irq_mask_i,
    output logic               irq_o,
    perf_ctr_bank_if.slave     rd
);

    logic [NUM_CTR-1:0] w_inc;
    logic [NUM_CTR-1:0] w_ovf;
    logic [WIDTH-1:0]   w_val [NUM_CTR];
    rd_sel_e            w_sel;
    logic [WIDTH-1:0]   w_rd_data;
    logic               w_rd_err;

    logic               r_rd_valid;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_rd_err;
    logic               r_irq;

    assign w_inc = event_i & {NUM_CTR{enable_i}};

`ifndef PERF_SNAPSHOT_EN
    wire w_unused_snap = snap_i;
`endif

    generate
        for (genvar k = 0; k < NUM_CTR; k++) begin : g_slice
            perf_ctr_slice #(
                .WIDTH (WIDTH)
            ) u_slice (
                .clk    (clk),
                .rst    (rst),
                .clr    (clr_i),
                .inc    (w_inc[k]),
`ifdef PERF_SNAPSHOT_EN
                .snap   (snap_i),
`endif
                .rd_val (w_val[k]),
                .ovf    (w_ovf[k])
            );
        end
    endgenerate

    // Response is formed from register contents before the accepting edge
    always_comb begin
        w_sel     = decode_addr(rd.rd_addr_i, NUM_CTR);
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (w_sel)
            RD_CTR: begin
                for (int k = 0; k < NUM_CTR; k++)
                    if (rd.rd_addr_i == ADDR_W'(k))
                        w_rd_data = w_val[k];
            end
            RD_OVF:  w_rd_data = WIDTH'(w_ovf);
            default: w_rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_rd_valid <= rd.rd_req_i;
            if (rd.rd_req_i) begin
                r_rd_data <= w_rd_data;
                r_rd_err  <= w_rd_err;
            end
            r_irq <= |(w_ovf & irq_mask_i);
        end
    end

    assign rd.rd_valid_o = r_rd_valid;
    assign rd.rd_data_o  = r_rd_data;
    assign rd.rd_err_o   = r_rd_err;
    assign irq_o         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_perf_ctr_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_ctr_bank
// Description : Directed self-checking bench for perf_ctr_bank (8-bit counters
//               so that wrap-around is reachable in a short run).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_ctr_bank;

    localparam int NUM_CTR = 8;
    localparam int WIDTH   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_CTR-1:0] event_i;
    logic               enable_i;
    logic               clr_i;
    logic               snap_i;
    logic [NUM_CTR-1:0] irq_mask_i;
    logic               irq_o;

    int n_chk  = 0;
    int n_fail = 0;

    perf_ctr_bank_if #(.WIDTH(WIDTH)) rd_bus ();

    perf_ctr_bank #(
        .NUM_CTR (NUM_CTR),
        .WIDTH   (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .event_i    (event_i),
        .enable_i   (enable_i),
        .clr_i      (clr_i),
        .snap_i     (snap_i),
        .irq_mask_i (irq_mask_i),
        .irq_o      (irq_o),
        .rd         (rd_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k, input int n);
        enable_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            event_i    = '0;
            event_i[k] = 1'b1;
            tick();
        end
        event_i = '0;
    endtask

    task automatic snap();
        snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] addr,
                          input logic [31:0] exp_d, input logic exp_e);
        rd_bus.rd_req_i  = 1'b1;
        rd_bus.rd_addr_i = addr;
        tick();
        rd_bus.rd_req_i  = 1'b0;
        check({tag, "_valid"}, {31'b0, rd_bus.rd_valid_o}, 32'd1);
        check({tag, "_data"},  {24'b0, rd_bus.rd_data_o},  exp_d);
        check({tag, "_err"},   {31'b0, rd_bus.rd_err_o},   {31'b0, exp_e});
    endtask

    initial begin
        rst              = 1'b1;
        event_i          = '0;
        enable_i         = 1'b0;
        clr_i            = 1'b0;
        snap_i           = 1'b0;
        irq_mask_i       = '0;
        rd_bus.rd_req_i  = 1'b0;
        rd_bus.rd_addr_i = '0;
        tick();
        tick();
        check("rst_valid", {31'b0, rd_bus.rd_valid_o}, 32'd0);
        check("rst_data",  {24'b0, rd_bus.rd_data_o},  32'd0);
        check("rst_err",   {31'b0, rd_bus.rd_err_o},   32'd0);
        check("rst_irq",   {31'b0, irq_o},             32'd0);
        rst = 1'b0;
        tick();

        // Five events on counter 2, then read it
        pulse(2, 5);
        snap();
        rd_chk("cnt2", 5'd2, 32'd5, 1'b0);
        tick();
        check("idle_valid", {31'b0, rd_bus.rd_valid_o}, 32'd0);
        check("hold_data",  {24'b0, rd_bus.rd_data_o},  32'd5);

        // Back-to-back reads
        rd_bus.rd_req_i  = 1'b1;
        rd_bus.rd_addr_i = 5'd2;
        tick();
        rd_bus.rd_addr_i = 5'd0;
        check("b2b0_valid", {31'b0, rd_bus.rd_valid_o}, 32'd1);
        check("b2b0_data",  {24'b0, rd_bus.rd_data_o},  32'd5);
        tick();
        rd_bus.rd_req_i = 1'b0;
        check("b2b1_valid", {31'b0, rd_bus.rd_valid_o}, 32'd1);
        check("b2b1_data",  {24'b0, rd_bus.rd_data_o},  32'd0);

        // Unmapped addresses
        rd_chk("addr10", 5'h10, 32'd0, 1'b1);
        rd_chk("addr8",  5'h08, 32'd0, 1'b1);

        // Events with enable low are ignored
        enable_i   = 1'b0;
        event_i[2] = 1'b1;
        tick();
        tick();
        event_i = '0;
        snap();
        rd_chk("disabled", 5'd2, 32'd5, 1'b0);

        // Wrap counter 0 and observe flag and interrupt
        irq_mask_i = 8'h01;
        pulse(0, 255);
        snap();
        rd_chk("cnt0_full", 5'd0, 32'hFF, 1'b0);
        rd_chk("ovf_pre",   5'h1F, 32'd0, 1'b0);
        pulse(0, 1);
        check("irq_same_edge", {31'b0, irq_o}, 32'd0);
        tick();
        check("irq_next", {31'b0, irq_o}, 32'd1);
        snap();
        rd_chk("ovf_set",   5'h1F, 32'd1, 1'b0);
        rd_chk("cnt0_wrap", 5'd0,  32'd0, 1'b0);
        irq_mask_i = 8'h00;
        tick();
        check("irq_masked", {31'b0, irq_o}, 32'd0);
        irq_mask_i = 8'h01;
        tick();
        check("irq_unmasked", {31'b0, irq_o}, 32'd1);

        // Clear coincident with an event and a read of the same counter
        pulse(1, 7);
        snap();
        clr_i            = 1'b1;
        enable_i         = 1'b1;
        event_i          = 8'h02;
        rd_bus.rd_req_i  = 1'b1;
        rd_bus.rd_addr_i = 5'd1;
        tick();
        clr_i           = 1'b0;
        event_i         = '0;
        rd_bus.rd_req_i = 1'b0;
        check("clr_rd_valid", {31'b0, rd_bus.rd_valid_o}, 32'd1);
        check("clr_rd_data",  {24'b0, rd_bus.rd_data_o},  32'd7);
        tick();
        check("clr_irq", {31'b0, irq_o}, 32'd0);
        snap();
        rd_chk("cnt1_clr", 5'd1,  32'd0, 1'b0);
        rd_chk("ovf_clr",  5'h1F, 32'd0, 1'b0);

        // Snapshot versus live read
        pulse(3, 10);
        snap();
        pulse(3, 4);
`ifdef PERF_SNAPSHOT_EN
        rd_chk("snap3", 5'd3, 32'd10, 1'b0);
`else
        rd_chk("snap3", 5'd3, 32'd14, 1'b0);
`endif

        // Reset mid-count with a pending read
        pulse(4, 3);
        snap();
        rd_chk("cnt4", 5'd4, 32'd3, 1'b0);
        rd_chk("pre_rst_err", 5'h11, 32'd0, 1'b1);
        rst              = 1'b1;
        enable_i         = 1'b1;
        event_i          = 8'h10;
        rd_bus.rd_req_i  = 1'b1;
        rd_bus.rd_addr_i = 5'd4;
        tick();
        rst             = 1'b0;
        event_i         = '0;
        rd_bus.rd_req_i = 1'b0;
        check("rst_rd_valid", {31'b0, rd_bus.rd_valid_o}, 32'd0);
        check("rst_rd_data",  {24'b0, rd_bus.rd_data_o},  32'd0);
        check("rst_rd_err",   {31'b0, rd_bus.rd_err_o},   32'd0);
        check("rst_irq2",     {31'b0, irq_o},             32'd0);
        tick();
        check("rst_no_pulse", {31'b0, rd_bus.rd_valid_o}, 32'd0);
        snap();
        rd_chk("cnt4_rst", 5'd4,  32'd0, 1'b0);
        rd_chk("ovf_rst",  5'h1F, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
